// File: rtl/mi_burst_word_bridge_pkg.sv
// Shared definitions for the mi_* burst to single-word bridge.
// Holds the FSM state encoding and the PAUSE down-counter width.
// Imported by the top; the beat counter is parameter-only and needs nothing from here.
package mi_burst_word_bridge_pkg;

  // FSM encoding: IDLE=0, XFER=1, PAUSE=2
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // PAUSE counter holds PAUSE_CYCLES-1, and PAUSE_CYCLES is at most 15
  localparam int PAUSE_CW = 4;

  // Reload value for the PAUSE counter: the state lasts `cycles` clocks
  function automatic logic [PAUSE_CW-1:0] pause_load(input int cycles);
    return PAUSE_CW'(cycles - 1);
  endfunction

endpackage

// File: rtl/mi_burst_beat_ctr.sv
// Burst address and remaining-beat counter for the mi_* bridge.
// Latency: load/step take effect on the next clk edge; last is combinational from the count.
// Backpressure: none of its own; the FSM only steps it on an accepted beat.
// Optional: MI_BRIDGE_WRAP_EN adds ld_wrap, which confines increments to the low WRAP_LOG2 bits.
module mi_burst_beat_ctr #(
  parameter int AW        = 20,
  parameter int LW        = 7,
  parameter int WRAP_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] ld_addr,
  input  logic [LW-1:0] ld_len,
`ifdef MI_BRIDGE_WRAP_EN
  input  logic          ld_wrap,
`endif
  output logic [AW-1:0] addr,
  output logic          last
);

  // Bits of the address that move during a wrap burst
  localparam logic [AW-1:0] WRAP_MASK = AW'((64'd1 << WRAP_LOG2) - 64'd1);

  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_next;
  logic          wrap_en;

`ifdef MI_BRIDGE_WRAP_EN
  logic wrap_q, wrap_d;

  // Wrap mode is captured with the command and held for the whole burst
  always_comb begin
    wrap_d = wrap_q;
    if (load) begin
      wrap_d = ld_wrap;
    end
  end

  // Wrap-mode register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_en = wrap_q;
`else
  // Without the wrap option every burst is linear
  assign wrap_en = 1'b0;
`endif

  // Next beat address: linear (rolls over at 2^AW) or wrapped inside the aligned block
  always_comb begin
    addr_inc  = addr_q + AW'(1);
    addr_next = addr_inc;
    if (wrap_en) begin
      addr_next = (addr_q & ~WRAP_MASK) | (addr_inc & WRAP_MASK);
    end
  end

  // Load a new command or advance by one beat; load has priority
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = ld_addr;
      cnt_d  = ld_len;
    end else if (step) begin
      addr_d = addr_next;
      cnt_d  = cnt_q - LW'(1);
    end
  end

  // Address and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/mi_burst_word_bridge.sv
// Splits mi_* burst commands (addr, len, rw) into single-word mem_* valid/ready requests.
// Latency: accept -> first mem_valid 1 cycle; beats back-to-back; last strobe -> mi_ready PAUSE_CYCLES+1.
// Backpressure: mem_valid/addr/we held until mem_ready; mi_ready low outside IDLE (MI_BRIDGE_WRAP_EN adds mi_wrap).
module mi_burst_word_bridge
  import mi_burst_word_bridge_pkg::*;
#(
  parameter int AW           = 20,
  parameter int DW           = 32,
  parameter int LW           = 7,
  parameter int PAUSE_CYCLES = 1,
  parameter int WRAP_LOG2    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] mi_addr,
  input  logic [LW-1:0] mi_len,
  input  logic          mi_rw,
  input  logic          mi_valid,
  output logic          mi_ready,
`ifdef MI_BRIDGE_WRAP_EN
  input  logic          mi_wrap,
`endif
  input  logic [DW-1:0] mi_wdata,
  output logic          mi_wack,
  output logic          mi_wlast,
  output logic [DW-1:0] mi_rdata,
  output logic          mi_rstb,
  output logic          mi_rlast,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_valid,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  state_t                state_q, state_d;
  logic [PAUSE_CW-1:0]   pause_q, pause_d;
  logic                  cmd_we_q, cmd_we_d;

  logic                  ctr_load;
  logic                  ctr_step;
  logic                  ctr_last;
  logic [AW-1:0]         cmd_addr;
  logic                  in_xfer;

  mi_burst_beat_ctr #(
    .AW        (AW),
    .LW        (LW),
    .WRAP_LOG2 (WRAP_LOG2)
  ) u_beat_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (ctr_load),
    .step    (ctr_step),
    .ld_addr (mi_addr),
    .ld_len  (mi_len),
`ifdef MI_BRIDGE_WRAP_EN
    .ld_wrap (mi_wrap),
`endif
    .addr    (cmd_addr),
    .last    (ctr_last)
  );

  // State, pause counter and direction registers; reset drops mem_valid at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pause_q  <= '0;
      cmd_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pause_q  <= pause_d;
      cmd_we_q <= cmd_we_d;
    end
  end

  // Next-state logic plus counter load/step decisions
  always_comb begin
    state_d  = state_q;
    pause_d  = pause_q;
    cmd_we_d = cmd_we_q;
    ctr_load = 1'b0;
    ctr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mi_valid) begin
          state_d  = ST_XFER;
          cmd_we_d = ~mi_rw;
          ctr_load = 1'b1;
        end
      end
      ST_XFER: begin
        // The request only moves on a completed beat
        if (mem_ready) begin
          if (ctr_last) begin
            state_d = ST_PAUSE;
            pause_d = pause_load(PAUSE_CYCLES);
          end else begin
            ctr_step = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        // mi_valid is ignored here; mi_ready is low
        if (pause_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          pause_d = pause_q - PAUSE_CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: backend request from state, master strobes straight from mem_ready
  always_comb begin
    in_xfer   = (state_q == ST_XFER);
    mi_ready  = (state_q == ST_IDLE);
    mem_valid = in_xfer;
    mem_we    = in_xfer & cmd_we_q;
    mem_addr  = cmd_addr;
    mem_wdata = mi_wdata;
    mi_rstb   = in_xfer & mem_ready & ~cmd_we_q;
    mi_wack   = in_xfer & mem_ready & cmd_we_q;
    mi_rlast  = mi_rstb & ctr_last;
    mi_wlast  = mi_wack & ctr_last;
    mi_rdata  = mi_rstb ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mi_burst_word_bridge.sv
// Directed bench for mi_burst_word_bridge: stimulus pushes expected beats into a
// scoreboard queue; an independent monitor pops and compares on every strobe.
module tb_mi_burst_word_bridge;

  logic        clk;
  logic        rst;
  logic [19:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw;
  logic        mi_valid;
  logic        mi_ready;
`ifdef MI_BRIDGE_WRAP_EN
  logic        mi_wrap;
`endif
  logic [31:0] mi_wdata;
  logic        mi_wack;
  logic        mi_wlast;
  logic [31:0] mi_rdata;
  logic        mi_rstb;
  logic        mi_rlast;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mi_burst_word_bridge #(
    .AW(20), .DW(32), .LW(7), .PAUSE_CYCLES(1), .WRAP_LOG2(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mi_addr   (mi_addr),
    .mi_len    (mi_len),
    .mi_rw     (mi_rw),
    .mi_valid  (mi_valid),
    .mi_ready  (mi_ready),
`ifdef MI_BRIDGE_WRAP_EN
    .mi_wrap   (mi_wrap),
`endif
    .mi_wdata  (mi_wdata),
    .mi_wack   (mi_wack),
    .mi_wlast  (mi_wlast),
    .mi_rdata  (mi_rdata),
    .mi_rstb   (mi_rstb),
    .mi_rlast  (mi_rlast),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rd;
    logic [19:0] addr;
    logic [31:0] dat;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Per-beat vectors for the next burst
  logic [19:0] v_addr[16];
  logic [31:0] v_dat[16];
  int          v_dly[16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mi_rstb || mi_wack) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {mi_rstb, mi_wack}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {mi_rstb, mi_wack}, e.rd ? 2'b10 : 2'b01);
        check("beat_addr", mem_addr, e.addr);
        check("beat_we", mem_we, !e.rd);
        if (e.rd) begin
          check("rdata", mi_rdata, e.dat);
          check("rlast", {mi_rlast, mi_wlast}, {e.last, 1'b0});
        end else begin
          check("wdata", mem_wdata, e.dat);
          check("wlast", {mi_rlast, mi_wlast}, {1'b0, e.last});
        end
      end
    end else begin
      check("rdata_idle_zero", mi_rdata, 32'h0);
      check("last_idle_zero", {mi_rlast, mi_wlast}, 2'b00);
    end
  end

  task automatic wait_mi_ready();
    int t = 0;
    while (!mi_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) check("mi_ready_timeout", mi_ready, 1'b1);
  endtask

  // Issue one command of n beats and play the backend using v_* vectors
  task automatic run_burst(input logic [19:0] a, input int n, input bit rd, input bit wrap);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.rd = rd; e.addr = v_addr[i]; e.dat = v_dat[i]; e.last = (i == n - 1);
      sb.push_back(e);
    end
    wait_mi_ready();
    mi_addr  = a;
    mi_len   = 7'(n - 1);
    mi_rw    = rd;
`ifdef MI_BRIDGE_WRAP_EN
    mi_wrap  = wrap;
`else
    if (wrap) check("wrap_unsupported", 1'b0, 1'b1);
`endif
    mi_valid = 1'b1;
    mi_wdata = v_dat[0];
    @(posedge clk); #1;
    mi_valid = 1'b0;
    mi_addr  = 20'h0;
    mi_len   = 7'h0;
    check("mem_valid_after_accept", mem_valid, 1'b1);
    check("mi_ready_low_in_xfer", mi_ready, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (!rd) mi_wdata = v_dat[i];
      for (int d = 0; d < v_dly[i]; d++) begin
        check("stall_valid", mem_valid, 1'b1);
        check("stall_addr", mem_addr, v_addr[i]);
        @(posedge clk); #1;
      end
      check("beat_valid", mem_valid, 1'b1);
      mem_ready = 1'b1;
      mem_rdata = rd ? v_dat[i] : 32'hBAD0_BAD0;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
    end
    check("pause_mi_ready", mi_ready, 1'b0);
    check("pause_mem_valid", mem_valid, 1'b0);
    @(posedge clk); #1;
    check("mi_ready_after_pause", mi_ready, 1'b1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; mi_addr = '0; mi_len = '0; mi_rw = 1'b0; mi_valid = 1'b0;
    mi_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
`ifdef MI_BRIDGE_WRAP_EN
    mi_wrap = 1'b0;
`endif
    #3;
    check("rst_mi_ready", mi_ready, 1'b1);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_strobes", {mi_rstb, mi_wack, mi_rlast, mi_wlast}, 4'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_mi_ready", mi_ready, 1'b1);

    // Single read, backend answers after 3 cycles
    v_addr[0] = 20'h00010; v_dat[0] = 32'hDEADBEEF; v_dly[0] = 3;
    run_burst(20'h00010, 1, 1'b1, 1'b0);

    // Four-beat write, backend ready every cycle
    for (int i = 0; i < 4; i++) begin
      v_addr[i] = 20'h00100 + 20'(i); v_dat[i] = 32'(i + 1); v_dly[i] = 0;
    end
    run_burst(20'h00100, 4, 1'b0, 1'b0);

    // Address rollover at the top of the space
    v_addr[0] = 20'hFFFFE; v_addr[1] = 20'hFFFFF; v_addr[2] = 20'h00000; v_addr[3] = 20'h00001;
    v_dat[0] = 32'hA0; v_dat[1] = 32'hA1; v_dat[2] = 32'hA2; v_dat[3] = 32'hA3;
    v_dly[0] = 0; v_dly[1] = 1; v_dly[2] = 0; v_dly[3] = 0;
    run_burst(20'hFFFFE, 4, 1'b1, 1'b0);

    // Backpressure: delays 0/5/1
    v_addr[0] = 20'h00300; v_addr[1] = 20'h00301; v_addr[2] = 20'h00302;
    v_dat[0] = 32'h11111111; v_dat[1] = 32'h22222222; v_dat[2] = 32'h33333333;
    v_dly[0] = 0; v_dly[1] = 5; v_dly[2] = 1;
    run_burst(20'h00300, 3, 1'b1, 1'b0);

    // Reset during beat 2 of an eight-beat read
    for (int i = 0; i < 2; i++) begin
      e.rd = 1'b1; e.addr = 20'h00200 + 20'(i); e.dat = 32'h500 + 32'(i); e.last = 1'b0;
      sb.push_back(e);
    end
    wait_mi_ready();
    mi_addr = 20'h00200; mi_len = 7'd7; mi_rw = 1'b1; mi_valid = 1'b1;
    @(posedge clk); #1;
    mi_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h500;
    @(posedge clk); #1;
    mem_rdata = 32'h501;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rst_test_beat2_addr", mem_addr, 20'h00202);
    check("rst_test_beat2_valid", mem_valid, 1'b1);
    #2;
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h502;
    #1;
    check("async_rst_mem_valid", mem_valid, 1'b0);
    check("async_rst_no_strobe", {mi_rstb, mi_rlast}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    #1;
    check("post_rst_mi_ready", mi_ready, 1'b1);
    check("post_rst_sb_drained", sb.size(), 0);
    @(posedge clk); #1;

    // Fresh single write after the aborted burst
    v_addr[0] = 20'h00040; v_dat[0] = 32'hCAFEF00D; v_dly[0] = 2;
    run_burst(20'h00040, 1, 1'b0, 1'b0);

`ifdef MI_BRIDGE_WRAP_EN
    // Wrap burst inside an 8-word block
    v_addr[0] = 20'h00106; v_addr[1] = 20'h00107; v_addr[2] = 20'h00100; v_addr[3] = 20'h00101;
    for (int i = 0; i < 4; i++) begin
      v_dat[i] = 32'hC0 + 32'(i); v_dly[i] = 0;
    end
    run_burst(20'h00106, 4, 1'b1, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
